// File: rtl/rbot_moves_pkg.sv
// Shared move-code definitions for the cube robot: code values, face indices,
// batch geometry and the executor/pulser state encodings.
package rbot_moves_pkg;

    localparam int unsigned NumNibbles = 15;
    localparam int unsigned NumFaces   = 6;
    localparam int unsigned BatchW     = 4 * NumNibbles;

    // Face indices into the step/dir vectors
    localparam logic [2:0] FaceR = 3'd0;
    localparam logic [2:0] FaceU = 3'd1;
    localparam logic [2:0] FaceF = 3'd2;
    localparam logic [2:0] FaceL = 3'd3;
    localparam logic [2:0] FaceB = 3'd4;
    localparam logic [2:0] FaceD = 3'd5;

    // Move codes: even = clockwise, odd = inverse; 0/1 empty, 14/15 invalid
    localparam logic [3:0] MvR  = 4'd2;
    localparam logic [3:0] MvRi = 4'd3;
    localparam logic [3:0] MvU  = 4'd4;
    localparam logic [3:0] MvUi = 4'd5;
    localparam logic [3:0] MvF  = 4'd6;
    localparam logic [3:0] MvFi = 4'd7;
    localparam logic [3:0] MvL  = 4'd8;
    localparam logic [3:0] MvLi = 4'd9;
    localparam logic [3:0] MvB  = 4'd10;
    localparam logic [3:0] MvBi = 4'd11;
    localparam logic [3:0] MvD  = 4'd12;
    localparam logic [3:0] MvDi = 4'd13;

    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StMove,
        StSettle,
        StDone
    } exec_state_e;

    typedef enum logic [1:0] {
        PsIdle,
        PsSetup,
        PsStepHi,
        PsStepLo
    } pulse_state_e;

    function automatic logic code_is_move(input logic [3:0] code);
        return (code >= MvR) && (code <= MvDi);
    endfunction

    function automatic logic code_is_bad(input logic [3:0] code);
        return code > MvDi;
    endfunction

    function automatic logic [2:0] code_face(input logic [3:0] code);
        return code[3:1] - 3'd1;
    endfunction

endpackage

// File: rtl/move_executor_if.sv
// Batch input and motor/status output bundle of the move executor.
interface move_executor_if;
    import rbot_moves_pkg::*;

    logic [BatchW-1:0]   moves;
    logic                new_moves;
    logic [NumFaces-1:0] step;
    logic [NumFaces-1:0] dir;
    logic                busy;
    logic                batch_done;
    logic                overflow;
    logic                bad_code;

    modport master (
        output moves, new_moves,
        input  step, dir, busy, batch_done, overflow, bad_code
    );

    modport slave (
        input  moves, new_moves,
        output step, dir, busy, batch_done, overflow, bad_code
    );
endinterface

// File: rtl/move_executor_step_pulser.sv
// Generates one quarter turn: a direction-setup interval followed by
// STEPS_PER_QTR step pulses. o_done is high in the final low-phase cycle.
module move_executor_step_pulser
    import rbot_moves_pkg::*;
#(
    parameter int unsigned STEPS_PER_QTR    = 50,
    parameter int unsigned STEP_HALF_PERIOD = 2500
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_start,
    output logic o_step,
    output logic o_done
);
    localparam int unsigned HalfW = $clog2(STEP_HALF_PERIOD + 1);
    localparam int unsigned StepW = $clog2(STEPS_PER_QTR + 1);
    localparam logic [HalfW-1:0] HalfLast = HalfW'(STEP_HALF_PERIOD - 1);
    localparam logic [StepW-1:0] StepLast = StepW'(STEPS_PER_QTR - 1);

    pulse_state_e     r_state, r_state_d;
    logic [HalfW-1:0] r_half_cnt, r_half_cnt_d;
    logic [StepW-1:0] r_step_cnt, r_step_cnt_d;
    logic             w_half_end;

    assign w_half_end = (r_half_cnt == HalfLast);

    // State and counter registers
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= PsIdle;
            r_half_cnt <= '0;
            r_step_cnt <= '0;
        end else begin
            r_state    <= r_state_d;
            r_half_cnt <= r_half_cnt_d;
            r_step_cnt <= r_step_cnt_d;
        end
    end

    // Phase sequencing: setup, then alternating high/low half periods
    always_comb begin
        r_state_d    = r_state;
        r_half_cnt_d = r_half_cnt;
        r_step_cnt_d = r_step_cnt;
        o_step       = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            PsIdle: begin
                if (i_start) begin
                    r_state_d    = PsSetup;
                    r_half_cnt_d = '0;
                    r_step_cnt_d = '0;
                end
            end
            PsSetup: begin
                if (w_half_end) begin
                    r_state_d    = PsStepHi;
                    r_half_cnt_d = '0;
                end else begin
                    r_half_cnt_d = r_half_cnt + 1'b1;
                end
            end
            PsStepHi: begin
                o_step = 1'b1;
                if (w_half_end) begin
                    r_state_d    = PsStepLo;
                    r_half_cnt_d = '0;
                end else begin
                    r_half_cnt_d = r_half_cnt + 1'b1;
                end
            end
            PsStepLo: begin
                if (w_half_end) begin
                    r_half_cnt_d = '0;
                    if (r_step_cnt == StepLast) begin
                        o_done       = 1'b1;
                        r_step_cnt_d = '0;
                        r_state_d    = PsIdle;
                    end else begin
                        r_step_cnt_d = r_step_cnt + 1'b1;
                        r_state_d    = PsStepHi;
                    end
                end else begin
                    r_half_cnt_d = r_half_cnt + 1'b1;
                end
            end
            default: r_state_d = PsIdle;
        endcase
    end

endmodule

// File: rtl/move_executor.sv
// Executes batches of up to 15 packed face moves, highest nibble first,
// driving per-face step/dir lines with a settle pause after each move.
module move_executor
    import rbot_moves_pkg::*;
#(
    parameter int unsigned STEPS_PER_QTR    = 50,
    parameter int unsigned STEP_HALF_PERIOD = 2500,
    parameter int unsigned SETTLE_CYCLES    = 65000
) (
    input  logic           i_clock,
    input  logic           i_reset,
    move_executor_if.slave bus
);
    localparam int unsigned SettleW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYCLES - 1);
    localparam logic [3:0] LastNibble = 4'(NumNibbles - 1);

    exec_state_e        r_state, r_state_d;
    logic [BatchW-1:0]  r_work, r_work_d;
    logic [BatchW-1:0]  r_pend, r_pend_d;
    logic               r_pend_valid, r_pend_valid_d;
    logic [3:0]         r_ptr, r_ptr_d;
    logic [2:0]         r_face, r_face_d;
    logic               r_cw, r_cw_d;
    logic [SettleW-1:0] r_settle_cnt, r_settle_cnt_d;
    logic               r_overflow, r_overflow_d;
    logic               r_bad_code, r_bad_code_d;

    logic [3:0]          w_code;
    logic                w_start;
    logic                w_pulse_step;
    logic                w_pulse_done;
    logic [NumFaces-1:0] w_face_onehot;

    assign w_code        = r_work[{r_ptr, 2'b00} +: 4];
    assign w_face_onehot = NumFaces'(1) << r_face;

    move_executor_step_pulser #(
        .STEPS_PER_QTR    (STEPS_PER_QTR),
        .STEP_HALF_PERIOD (STEP_HALF_PERIOD)
    ) u_pulser (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_start (w_start),
        .o_step  (w_pulse_step),
        .o_done  (w_pulse_done)
    );

    // Sequencer state and batch registers
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_work       <= '0;
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
            r_ptr        <= '0;
            r_face       <= '0;
            r_cw         <= 1'b0;
            r_settle_cnt <= '0;
            r_overflow   <= 1'b0;
            r_bad_code   <= 1'b0;
        end else begin
            r_state      <= r_state_d;
            r_work       <= r_work_d;
            r_pend       <= r_pend_d;
            r_pend_valid <= r_pend_valid_d;
            r_ptr        <= r_ptr_d;
            r_face       <= r_face_d;
            r_cw         <= r_cw_d;
            r_settle_cnt <= r_settle_cnt_d;
            r_overflow   <= r_overflow_d;
            r_bad_code   <= r_bad_code_d;
        end
    end

    // Next-state logic: nibble scan, move dispatch, settle, batch chaining
    always_comb begin
        r_state_d       = r_state;
        r_work_d        = r_work;
        r_pend_d        = r_pend;
        r_pend_valid_d  = r_pend_valid;
        r_ptr_d         = r_ptr;
        r_face_d        = r_face;
        r_cw_d          = r_cw;
        r_settle_cnt_d  = r_settle_cnt;
        r_overflow_d    = r_overflow;
        r_bad_code_d    = r_bad_code;
        w_start         = 1'b0;
        bus.batch_done  = 1'b0;

        // IDLE and DONE take the strobe directly; elsewhere it queues
        if (bus.new_moves && (r_state != StIdle) && (r_state != StDone)) begin
            if (r_pend_valid) begin
                r_overflow_d = 1'b1;
            end else begin
                r_pend_d       = bus.moves;
                r_pend_valid_d = 1'b1;
            end
        end

        case (r_state)
            StIdle: begin
                if (bus.new_moves) begin
                    r_work_d  = bus.moves;
                    r_ptr_d   = LastNibble;
                    r_state_d = StScan;
                end
            end
            StScan: begin
                if (code_is_move(w_code)) begin
                    r_face_d  = code_face(w_code);
                    r_cw_d    = ~w_code[0];
                    w_start   = 1'b1;
                    r_state_d = StMove;
                end else begin
                    if (code_is_bad(w_code)) begin
                        r_bad_code_d = 1'b1;
                    end
                    if (r_ptr == '0) begin
                        r_state_d = StDone;
                    end else begin
                        r_ptr_d = r_ptr - 1'b1;
                    end
                end
            end
            StMove: begin
                if (w_pulse_done) begin
                    r_settle_cnt_d = '0;
                    r_state_d      = StSettle;
                end
            end
            StSettle: begin
                if (r_settle_cnt == SettleLast) begin
                    if (r_ptr == '0) begin
                        r_state_d = StDone;
                    end else begin
                        r_ptr_d   = r_ptr - 1'b1;
                        r_state_d = StScan;
                    end
                end else begin
                    r_settle_cnt_d = r_settle_cnt + 1'b1;
                end
            end
            StDone: begin
                bus.batch_done = 1'b1;
                if (r_pend_valid) begin
                    r_work_d  = r_pend;
                    r_ptr_d   = LastNibble;
                    r_state_d = StScan;
                    // Pending slot frees this cycle, so a same-cycle strobe refills it
                    if (bus.new_moves) begin
                        r_pend_d = bus.moves;
                    end else begin
                        r_pend_valid_d = 1'b0;
                    end
                end else if (bus.new_moves) begin
                    r_work_d  = bus.moves;
                    r_ptr_d   = LastNibble;
                    r_state_d = StScan;
                end else begin
                    r_state_d = StIdle;
                end
            end
            default: r_state_d = StIdle;
        endcase
    end

    // Motor and status outputs; only the active face bit can be set
    always_comb begin
        bus.step     = '0;
        bus.dir      = '0;
        bus.busy     = (r_state != StIdle);
        bus.overflow = r_overflow;
        bus.bad_code = r_bad_code;
        if ((r_state == StMove) && w_pulse_step) begin
            bus.step = w_face_onehot;
        end
        if (((r_state == StMove) || (r_state == StSettle)) && r_cw) begin
            bus.dir = w_face_onehot;
        end
    end

endmodule
